// File: rtl/matrix_pkg.sv
// Shared cell encoding, scan FSM states and default board geometry for the
// matrix board blocks (matrix_mem and its readers).
package matrix_pkg;

    localparam int unsigned DEF_WIDTH   = 6;
    localparam int unsigned DEF_COORD_W = 3;
    localparam int unsigned CELL_W      = 2;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_SUB   = 2'b01;
    localparam cell_t CELL_HIT   = 2'b10;
    localparam cell_t CELL_MISS  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } scan_state_t;

endpackage

// File: rtl/matrix_scan_ptr.sv
// Row-major x/y raster pointer over a WIDTH x WIDTH board with a last-cell flag.
module matrix_scan_ptr
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last_c
);

    localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(WIDTH - 1);

    assign last_c = (x == MAX_COORD) && (y == MAX_COORD);

    // After the last cell the pointer folds back to the origin rather than
    // leaving the board.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == MAX_COORD) begin
                x <= '0;
                y <= last_c ? '0 : y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_reader.sv
// Walks the board in raster order, reads each cell from matrix_mem, streams
// (x, y, cell) to the renderer and tallies submarine / hit cells.
module matrix_scan_reader
    import matrix_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_req,
    input  logic [CELL_W-1:0]  mem_data,
    input  logic               mem_valid,
    output logic [COORD_W-1:0] cell_x,
    output logic [COORD_W-1:0] cell_y,
    output logic [CELL_W-1:0]  cell_data,
    output logic               cell_valid,
    input  logic               cell_ready,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   sub_count,
    output logic [CNT_W-1:0]   hit_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [TMR_W-1:0] timer_q;

    logic start_c;
    logic capture_c;
    logic handshake_c;
    logic timeout_c;
    logic last_cell_c;

    matrix_scan_ptr #(
        .WIDTH   (WIDTH),
        .COORD_W (COORD_W)
    ) u_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (start_c),
        .advance (handshake_c),
        .x       (rd_x),
        .y       (rd_y),
        .last_c  (last_cell_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks every other event outside IDLE, so it also masks
    // a coincident handshake, capture or timeout.
    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        capture_c   = 1'b0;
        handshake_c = 1'b0;
        timeout_c   = 1'b0;
        if ((state_q != IDLE) && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        start_c = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: state_d = WAIT;
                WAIT: begin
                    if (mem_valid) begin
                        capture_c = 1'b1;
                        state_d   = OUT;
                    end else if (timer_q == TMR_LAST) begin
                        timeout_c = 1'b1;
                        state_d   = DONE;
                    end
                end
                OUT: begin
                    if (cell_ready) begin
                        handshake_c = 1'b1;
                        state_d     = last_cell_c ? DONE : REQ;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_req     <= 1'b0;
            cell_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rd_req     <= (state_d == REQ);
            cell_valid <= (state_d == OUT);
            done       <= (state_d == DONE);
            busy       <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
        end else if (state_q == REQ) begin
            timer_q <= '0;
        end else if (state_q == WAIT) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cell_x    <= '0;
            cell_y    <= '0;
            cell_data <= '0;
            sub_count <= '0;
            hit_count <= '0;
            error     <= 1'b0;
        end else begin
            if (start_c) begin
                sub_count <= '0;
                hit_count <= '0;
                error     <= 1'b0;
            end
            if (timeout_c) begin
                error <= 1'b1;
            end
            if (capture_c) begin
                cell_x    <= rd_x;
                cell_y    <= rd_y;
                cell_data <= mem_data;
            end
            if (handshake_c) begin
                if (cell_data == CELL_SUB) begin
                    sub_count <= sub_count + CNT_W'(1);
                end
                if (cell_data == CELL_HIT) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/matrix_scan_reader.md
Name: matrix_scan_reader

Overview:
- Read-side companion to matrix_mem. Walks the WIDTH x WIDTH game board in row-major order and issues one read request per cell on matrix_mem's read port.
- Waits for each returned cell value, then streams (x, y, cell) to the display/status path over a valid/ready handshake.
- Tallies submarine and hit cells for end-of-turn scoring. Sits between matrix_mem and the board renderer / score logic.

Parameters:
- WIDTH, 6, board dimension in cells per row and per column.
- COORD_W, 3, coordinate width in bits; must satisfy 2^COORD_W >= WIDTH.
- CNT_W, 6, tally counter width in bits; must satisfy 2^CNT_W > WIDTH*WIDTH.
- TIMEOUT, 8, maximum cycles spent in WAIT before the scan aborts with an error.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- rd_x  out  COORD_W  column of the current read request.
- rd_y  out  COORD_W  row of the current read request.
- rd_req  out  1  one-cycle read strobe to matrix_mem.
- mem_data  in  2  cell value returned by matrix_mem.
- mem_valid  in  1  mem_data qualifier.
- cell_x  out  COORD_W  column of the streamed cell.
- cell_y  out  COORD_W  row of the streamed cell.
- cell_data  out  2  value of the streamed cell.
- cell_valid  out  1  stream valid.
- cell_ready  in  1  stream ready from the consumer.
- busy  out  1  high from the cycle after start is accepted until IDLE is re-entered.
- done  out  1  one-cycle pulse on scan completion or on timeout.
- error  out  1  sticky timeout flag; cleared on the next accepted start.
- sub_count  out  CNT_W  number of cells equal to CELL_SUB.
- hit_count  out  CNT_W  number of cells equal to CELL_HIT.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: every output is 0. State is IDLE, the scan pointer is (0,0), the WAIT timer is 0.
- Cell encoding: CELL_EMPTY = 00, CELL_SUB = 01, CELL_HIT = 10, CELL_MISS = 11.
- IDLE:
  - start=1 and abort=0: clear sub_count, hit_count and error; set the pointer to (0,0); go to REQ.
  - start together with abort: start is ignored.
- REQ (exactly one cycle):
  - rd_req=1, rd_x/rd_y = pointer; the timer is cleared.
  - Always goes to WAIT.
- WAIT:
  - rd_req=0; the timer increments every cycle.
  - mem_valid=1: capture mem_data into cell_data, the pointer into cell_x/cell_y; go to OUT.
  - Timer reaches TIMEOUT-1 with mem_valid=0: set error=1; go to DONE. Tallies keep their partial values.
  - mem_valid arriving in any state other than WAIT is ignored.
- OUT:
  - cell_valid=1. cell_x, cell_y and cell_data are held stable until cell_ready=1.
  - On the handshake (cell_valid & cell_ready):
    - CELL_SUB increments sub_count; CELL_HIT increments hit_count.
    - Pointer advance: x increments; x=WIDTH-1 wraps to x=0 with y+1.
    - If the pointer was (WIDTH-1, WIDTH-1), go to DONE; otherwise go to REQ.
  - cell_valid drops the cycle after the handshake.
- DONE (exactly one cycle): done=1; go to IDLE. busy deasserts on IDLE entry.
- abort=1 in any non-IDLE state:
  - Next state is IDLE. cell_valid, rd_req and busy drop next cycle.
  - No done pulse. Counts and error hold their values.
- Latency, with mem_valid returned the cycle after rd_req and cell_ready tied high:
  - 3 cycles per cell.
  - The first rd_req is 1 cycle after start is sampled.
  - done is asserted 3*WIDTH*WIDTH+1 cycles after start is sampled (109 cycles for WIDTH=6).
- Reset asserted mid-scan: immediate return to reset values; no done pulse.
- start pulses while busy are ignored.

Decomposition:
- Shared package (matrix_pkg):
  - Cell encoding constants CELL_EMPTY, CELL_SUB, CELL_HIT, CELL_MISS.
  - The FSM state enum (IDLE, REQ, WAIT, OUT, DONE).
  - Default WIDTH/COORD_W. matrix_mem takes the same constants.
- One natural sub-module, matrix_scan_ptr: the x/y raster counter with advance, wrap and a last-cell flag.

Test Plan:
1. Empty board, cell_ready held 1, start pulsed → 36 handshakes in order (0,0),(1,0),…,(5,5), all cell_data=00; done at cycle 109 after start; sub_count=0, hit_count=0, error=0.
2. Board with (1,1)=01, (2,2)=10, (5,5)=01 → those cells stream exactly those values; done with sub_count=2, hit_count=1.
3. cell_ready held 0 for 5 cycles on cell (3,0) → cell_valid stays 1 and cell_x=3, cell_y=0, cell_data stay stable throughout; no rd_req until after the handshake; no cell skipped or duplicated.
4. Memory model withholds mem_valid for cell (2,1) → after 8 cycles in WAIT: error=1 and a done pulse; sub/hit counts reflect cells (0,0)..(1,1) only; next start clears error to 0.
5. abort asserted during the OUT state of cell (4,2) → next cycle: IDLE, busy=0, cell_valid=0, no done pulse; a following start rescans from (0,0) with counts cleared.
6. rstn driven low mid-scan, and start re-pulsed while busy → all outputs 0 during reset; the start pulse issued while busy produces no second scan and does not reset the pointer.
